// File: rtl/csr_access_if.sv
// ----------------------------------------------------------------------------
// csr_access_if : request/response and CSR register-file signals for csr_access_ctrl
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface csr_access_if;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [2:0]  req_op_i;
  logic [11:0] req_addr_i;
  logic [31:0] req_src_i;
  logic        req_src_zero_i;
  logic        resp_valid_o;
  logic        resp_ready_i;
  logic [31:0] resp_rdata_o;
  logic        resp_err_o;
  logic [31:0] csr_raddr_o;
  logic [31:0] csr_rdata_i;
  logic        csr_we_o;
  logic [31:0] csr_waddr_o;
  logic [31:0] csr_wdata_o;

  // Execute stage and CSR register file together form the master side.
  modport master (
    output req_valid_i, req_op_i, req_addr_i, req_src_i, req_src_zero_i,
    output resp_ready_i, csr_rdata_i,
    input  req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o,
    input  csr_raddr_o, csr_we_o, csr_waddr_o, csr_wdata_o
  );

  modport slave (
    input  req_valid_i, req_op_i, req_addr_i, req_src_i, req_src_zero_i,
    input  resp_ready_i, csr_rdata_i,
    output req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o,
    output csr_raddr_o, csr_we_o, csr_waddr_o, csr_wdata_o
  );
endinterface

`default_nettype wire

// File: rtl/csr_access_ctrl.sv
// ----------------------------------------------------------------------------
// csr_access_ctrl : Zicsr read-modify-write sequencer in front of a CSR file
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module csr_access_ctrl #(
  parameter bit RO_CHECK = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  csr_access_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [2:0]  op;
  logic [11:0] addr;
  logic [31:0] src;
  logic        src_zero;
  logic [31:0] rdata;
  logic        err;

  logic        accept;
  logic        illegal;
  logic        wr_en;
  logic        blocked;
  logic [31:0] new_val;
  logic        req_ready;
  logic        resp_valid;
  logic        we;
  logic [31:0] wdata;

  always_comb begin
    accept  = bus.req_valid_i && (state == IDLE);
    illegal = (bus.req_op_i[1:0] == 2'b00);
    wr_en   = (op[1:0] == 2'b01) || !src_zero;
    blocked = wr_en && RO_CHECK && (addr[11:10] == 2'b11);
    case (op[1:0])
      2'b10:   new_val = bus.csr_rdata_i | src;
      2'b11:   new_val = bus.csr_rdata_i & ~src;
      default: new_val = src;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    we         = 1'b0;
    wdata      = 32'd0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (bus.req_valid_i) state_nxt = illegal ? RESP : RD;
      end
      RD: state_nxt = WR;
      WR: begin
        // Gated by rst so a reset landing on the commit edge suppresses the write.
        we        = wr_en && !blocked && rst;
        wdata     = new_val;
        state_nxt = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        if (bus.resp_ready_i) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Illegal ops leave the address untouched so the CSR file sees no access.
  always_ff @(posedge clk) begin
    if (!rst) begin
      op       <= 3'd0;
      addr     <= 12'd0;
      src      <= 32'd0;
      src_zero <= 1'b0;
      rdata    <= 32'd0;
      err      <= 1'b0;
    end else begin
      if (accept) begin
        rdata <= 32'd0;
        err   <= illegal;
        if (!illegal) begin
          op       <= bus.req_op_i;
          addr     <= bus.req_addr_i;
          src      <= bus.req_op_i[2] ? {27'd0, bus.req_src_i[4:0]} : bus.req_src_i;
          src_zero <= bus.req_src_zero_i;
        end
      end
      if (state == WR) begin
        rdata <= bus.csr_rdata_i;
        err   <= blocked;
      end
    end
  end

  assign bus.req_ready_o  = req_ready;
  assign bus.resp_valid_o = resp_valid;
  assign bus.resp_rdata_o = rdata;
  assign bus.resp_err_o   = err;
  assign bus.csr_raddr_o  = {20'd0, addr};
  assign bus.csr_waddr_o  = {20'd0, addr};
  assign bus.csr_we_o     = we;
  assign bus.csr_wdata_o  = wdata;

endmodule

`default_nettype wire

// File: tb/tb_csr_access_ctrl.sv
// ----------------------------------------------------------------------------
// tb_csr_access_ctrl : directed vector bench for csr_access_ctrl with a CSR file model
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_csr_access_ctrl;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  csr_access_if bus ();

  csr_access_ctrl #(.RO_CHECK(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // CSR register file: one-cycle registered read, write on csr_we_o.
  logic [31:0] mem [0:4095];
  logic        pl_en;
  logic [11:0] pl_addr;
  logic [31:0] pl_data;

  always @(posedge clk) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    else if (bus.csr_we_o) mem[bus.csr_waddr_o[11:0]] <= bus.csr_wdata_o;
    bus.csr_rdata_i <= mem[bus.csr_raddr_o[11:0]];
  end

  typedef struct {
    logic [2:0]  op;
    logic [11:0] addr;
    logic [31:0] src;
    logic        sz;
    int          lat;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
    logic [11:0] raddr;
  } vec_t;

  vec_t vecs [13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic preload(input logic [11:0] a, input logic [31:0] d);
    @(negedge clk);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    @(posedge clk);
    #1 pl_en = 1'b0;
  endtask

  task automatic issue(input logic [2:0] op, input logic [11:0] a, input logic [31:0] s, input logic sz);
    @(negedge clk);
    bus.req_valid_i = 1'b1; bus.req_op_i = op; bus.req_addr_i = a;
    bus.req_src_i = s; bus.req_src_zero_i = sz;
    @(posedge clk);
    #1 bus.req_valid_i = 1'b0;
  endtask

  task automatic collect(output int lat, output int nwe, output int we_cyc,
                         output logic [31:0] wa, output logic [31:0] wd);
    lat = -1; nwe = 0; we_cyc = -1; wa = '0; wd = '0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (bus.csr_we_o) begin
        nwe++; we_cyc = c; wa = bus.csr_waddr_o; wd = bus.csr_wdata_o;
      end
      if (bus.resp_valid_o) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic release_resp();
    bus.resp_ready_i = 1'b1;
    @(posedge clk);
    #1 bus.resp_ready_i = 1'b0;
    @(negedge clk);
    chk("req_ready_after_resp", {31'd0, bus.req_ready_o}, 32'd1);
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int          lat, nwe, we_cyc;
    logic [31:0] wa, wd;
    issue(v.op, v.addr, v.src, v.sz);
    collect(lat, nwe, we_cyc, wa, wd);
    $display("vector %0d op=%b addr=0x%03h", idx, v.op, v.addr);
    chk("latency", lat, v.lat);
    chk("we_count", nwe, {31'd0, v.we});
    if (v.we) begin
      chk("we_cycle", we_cyc, 32'd2);
      chk("waddr", wa, {20'd0, v.addr});
      chk("wdata", wd, v.wdata);
    end
    chk("rdata", bus.resp_rdata_o, v.rdata);
    chk("err", {31'd0, bus.resp_err_o}, {31'd0, v.err});
    chk("raddr", bus.csr_raddr_o, {20'd0, v.raddr});
    chk("req_ready_in_resp", {31'd0, bus.req_ready_o}, 32'd0);
    release_resp();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat, nwe, we_cyc;
    logic [31:0] wa, wd;
    vec_t        v;
    checks = 0; errors = 0;
    rst = 1'b0; pl_en = 1'b0; pl_addr = '0; pl_data = '0;
    bus.req_valid_i = 1'b0; bus.req_op_i = '0; bus.req_addr_i = '0;
    bus.req_src_i = '0; bus.req_src_zero_i = 1'b0; bus.resp_ready_i = 1'b0;

    //           op      addr     src            sz lat we wdata          rdata          err raddr
    vecs[0]  = '{3'b001, 12'h305, 32'h8000_0100, 0, 3, 1, 32'h8000_0100, 32'h0,         0, 12'h305};
    vecs[1]  = '{3'b010, 12'h300, 32'h0000_0080, 0, 3, 1, 32'h0000_0088, 32'h8,         0, 12'h300};
    vecs[2]  = '{3'b011, 12'h300, 32'h0000_0008, 0, 3, 1, 32'h0000_0080, 32'h88,        0, 12'h300};
    vecs[3]  = '{3'b010, 12'h341, 32'h0,         1, 3, 0, 32'h0,         32'h1234,      0, 12'h341};
    vecs[4]  = '{3'b110, 12'h341, 32'hFFFF_FFE0, 1, 3, 0, 32'h0,         32'h1234,      0, 12'h341};
    vecs[5]  = '{3'b001, 12'hF14, 32'h5,         0, 3, 0, 32'h0,         32'h0,         1, 12'hF14};
    vecs[6]  = '{3'b100, 12'h123, 32'hDEAD_BEEF, 0, 1, 0, 32'h0,         32'h0,         1, 12'hF14};
    vecs[7]  = '{3'b101, 12'h340, 32'hFFFF_FFE7, 0, 3, 1, 32'h7,         32'hAAAA_0000, 0, 12'h340};
    vecs[8]  = '{3'b111, 12'h340, 32'h3,         0, 3, 1, 32'h4,         32'h7,         0, 12'h340};
    vecs[9]  = '{3'b010, 12'hC00, 32'h0,         1, 3, 0, 32'h0,         32'h55,        0, 12'hC00};
    vecs[10] = '{3'b110, 12'h305, 32'h1F,        0, 3, 1, 32'h8000_011F, 32'h8000_0100, 0, 12'h305};
    vecs[11] = '{3'b000, 12'h555, 32'h1,         0, 1, 0, 32'h0,         32'h0,         1, 12'h305};
    vecs[12] = '{3'b011, 12'hF14, 32'h0,         1, 3, 0, 32'h0,         32'h0,         0, 12'hF14};

    preload(12'h300, 32'h8);
    preload(12'h341, 32'h1234);
    preload(12'hF14, 32'h0);
    preload(12'h340, 32'hAAAA_0000);
    preload(12'hC00, 32'h55);
    preload(12'h305, 32'h0);

    @(negedge clk);
    chk("rst_req_ready", {31'd0, bus.req_ready_o}, 32'd1);
    chk("rst_resp_valid", {31'd0, bus.resp_valid_o}, 32'd0);
    chk("rst_we", {31'd0, bus.csr_we_o}, 32'd0);
    chk("rst_rdata", bus.resp_rdata_o, 32'd0);
    chk("rst_err", {31'd0, bus.resp_err_o}, 32'd0);
    chk("rst_raddr", bus.csr_raddr_o, 32'd0);
    chk("rst_waddr", bus.csr_waddr_o, 32'd0);
    chk("rst_wdata", bus.csr_wdata_o, 32'd0);
    rst = 1'b1;

    for (int i = 0; i < 13; i++) run_vec(i, vecs[i]);

    chk("mem_300", mem[12'h300], 32'h80);
    chk("mem_340", mem[12'h340], 32'h4);
    chk("mem_f14", mem[12'hF14], 32'h0);
    chk("mem_305", mem[12'h305], 32'h8000_011F);
    chk("mem_341", mem[12'h341], 32'h1234);

    // Response back-pressure with a competing request during the stall.
    issue(3'b001, 12'h305, 32'h1, 1'b0);
    collect(lat, nwe, we_cyc, wa, wd);
    chk("bp_latency", lat, 32'd3);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_resp_valid", {31'd0, bus.resp_valid_o}, 32'd1);
      chk("bp_rdata", bus.resp_rdata_o, 32'h8000_011F);
      chk("bp_err", {31'd0, bus.resp_err_o}, 32'd0);
      chk("bp_req_ready", {31'd0, bus.req_ready_o}, 32'd0);
      chk("bp_we", {31'd0, bus.csr_we_o}, 32'd0);
      if (i == 1) begin
        bus.req_valid_i = 1'b1; bus.req_op_i = 3'b001;
        bus.req_addr_i = 12'h300; bus.req_src_i = 32'hFF; bus.req_src_zero_i = 1'b0;
      end
    end
    bus.req_valid_i = 1'b0;
    release_resp();
    chk("bp_mem_305", mem[12'h305], 32'h1);
    chk("bp_mem_300", mem[12'h300], 32'h80);

    // Reset arriving while the write is being presented.
    issue(3'b001, 12'h300, 32'h1234_5678, 1'b0);
    @(negedge clk);
    chk("rwr_rd_we", {31'd0, bus.csr_we_o}, 32'd0);
    @(negedge clk);
    chk("rwr_wr_we", {31'd0, bus.csr_we_o}, 32'd1);
    chk("rwr_wr_wdata", bus.csr_wdata_o, 32'h1234_5678);
    rst = 1'b0;
    #1 chk("rwr_we_gated", {31'd0, bus.csr_we_o}, 32'd0);
    @(negedge clk);
    chk("rwr_we", {31'd0, bus.csr_we_o}, 32'd0);
    chk("rwr_resp_valid", {31'd0, bus.resp_valid_o}, 32'd0);
    chk("rwr_req_ready", {31'd0, bus.req_ready_o}, 32'd1);
    chk("rwr_rdata", bus.resp_rdata_o, 32'd0);
    chk("rwr_mem_300", mem[12'h300], 32'h80);
    rst = 1'b1;

    v = '{3'b010, 12'h300, 32'h0, 1, 3, 0, 32'h0, 32'h80, 0, 12'h300};
    run_vec(13, v);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
